hft_stream_arbiter: RTL and testbench

Round-robin AXI-Stream arbiter that shares a single custom IP core datapath among NUM_REQ requesters (market-data feeds, order-book engines). Accepts one beat per grant from the requesters, forwards it to the core's slave stream, records the requester index in an in-order tag FIFO, and routes each core result back with a destination tag. Sits between the feed handlers and the custom IP core; the core's internal control/status registers are untouched.

---
 rtl/hft_arb_pkg.sv | 40 ++++
 rtl/hft_tag_fifo.sv | 52 +++++
 rtl/hft_stream_arbiter.sv | 121 ++++++++++++
 tb/tb_hft_stream_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hft_arb_pkg.sv
// Shared types and helpers for the stream arbiter: FSM state encoding,
// width helpers and the round-robin selection function.
package hft_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Counter width able to hold the value m itself (0..m).
    function automatic int cnt_w(input int m);
        return $clog2(m) + 1;
    endfunction

    // First valid index at or after ptr, wrapping modulo n (n <= 8).
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [2:0] res;
        logic       found;
        int         idx;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!found && (i < n) && valid[idx]) begin
                res   = 3'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hft_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each beat inside the
// core so results can be routed back. Exposes its fill count.
module hft_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking; push+pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/hft_stream_arbiter.sv
// Round-robin AXI-Stream arbiter sharing one core datapath among NUM_REQ
// requesters. One beat per grant goes to the core; a tag FIFO records the
// owner so each core result leaves with the right destination index.
module hft_stream_arbiter
    import hft_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      s_req_tdata,
    input  logic [NUM_REQ-1:0]                 s_req_tvalid,
    output logic [NUM_REQ-1:0]                 s_req_tready,
    output logic [DATA_WIDTH-1:0]              m_core_tdata,
    output logic                               m_core_tvalid,
    input  logic                               m_core_tready,
    input  logic [DATA_WIDTH-1:0]              s_core_tdata,
    input  logic                               s_core_tvalid,
    output logic                               s_core_tready,
    output logic [DATA_WIDTH-1:0]              m_rsp_tdata,
    output logic [idx_w(NUM_REQ)-1:0]          m_rsp_tdest,
    output logic                               m_rsp_tvalid,
    input  logic                               m_rsp_tready,
    output logic [cnt_w(MAX_OUTSTANDING)-1:0]  outstanding,
    output logic                               err_orphan
);
    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = cnt_w(MAX_OUTSTANDING);

    arb_state_e       state;
    logic             core_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick;
    logic             core_hs;
    logic             rsp_hs;
    logic             tag_full;
    logic             tag_empty;
    logic [IDX_W-1:0] tag_head;
    logic [CNT_W-1:0] tag_count;

    assign pick    = IDX_W'(rr_pick(8'(s_req_tvalid), 3'(rr_ptr), NUM_REQ));
    assign core_hs = core_vld & m_core_tready;
    assign rsp_hs  = m_rsp_tvalid & m_rsp_tready;

    // Grant FSM: pick in IDLE, hold the grant until the core takes the beat.
    // Blocking on the registered full flag means a same-cycle pop only
    // frees the slot for the following arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            core_vld  <= 1'b0;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_req_tvalid && !tag_full) begin
                        grant_idx <= pick;
                        core_vld  <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (m_core_tready) begin
                        rr_ptr   <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        core_vld <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    core_vld <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Forward the granted requester's beat; ready goes only to that requester.
    always_comb begin
        m_core_tdata = '0;
        s_req_tready = '0;
        if (core_vld) begin
            m_core_tdata            = s_req_tdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            s_req_tready[grant_idx] = m_core_tready;
        end
    end

    assign m_core_tvalid = core_vld;

    hft_tag_fifo #(
        .W     (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (core_hs),
        .din   (grant_idx),
        .pop   (rsp_hs),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    // Results pass straight through; without a pending tag they are refused.
    assign m_rsp_tvalid  = s_core_tvalid & ~tag_empty;
    assign s_core_tready = m_rsp_tready & ~tag_empty;
    assign m_rsp_tdata   = s_core_tdata;
    assign m_rsp_tdest   = tag_empty ? '0 : tag_head;
    assign outstanding   = tag_count;

    // Sticky flag for a core result that has no owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            err_orphan <= 1'b0;
        else if (s_core_tvalid && tag_empty) err_orphan <= 1'b1;
    end

endmodule

// File: tb/tb_hft_stream_arbiter.sv
// Bench for hft_stream_arbiter: requester/core stubs driven from queues,
// expected responses scoreboarded at core acceptance.
module tb_hft_stream_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MO = 8;
    localparam int IW = 2;
    localparam int CW = 4;
    localparam logic [31:0] K = 32'hABCDEF01;

    typedef struct packed {
        logic [IW-1:0] dest;
        logic [31:0]   data;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*DW-1:0] s_req_tdata;
    logic [NR-1:0]    s_req_tvalid;
    logic [NR-1:0]    s_req_tready;
    logic [DW-1:0]    m_core_tdata;
    logic             m_core_tvalid;
    logic             m_core_tready;
    logic [DW-1:0]    s_core_tdata;
    logic             s_core_tvalid;
    logic             s_core_tready;
    logic [DW-1:0]    m_rsp_tdata;
    logic [IW-1:0]    m_rsp_tdest;
    logic             m_rsp_tvalid;
    logic             m_rsp_tready;
    logic [CW-1:0]    outstanding;
    logic             err_orphan;

    rsp_t        sb_q[$];
    logic [31:0] req_q[NR][$];
    int          exp_grant_q[$];
    logic [31:0] core_q[$];
    int          hs_cyc_q[$];
    int          checks = 0;
    int          errs = 0;
    int          cyc = 0;
    bit          core_en = 1'b1;
    bit          orphan_drv = 1'b0;
    int          rel_req = 0;
    int          rel_done = 0;

    hft_stream_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst(rst),
        .s_req_tdata(s_req_tdata), .s_req_tvalid(s_req_tvalid), .s_req_tready(s_req_tready),
        .m_core_tdata(m_core_tdata), .m_core_tvalid(m_core_tvalid), .m_core_tready(m_core_tready),
        .s_core_tdata(s_core_tdata), .s_core_tvalid(s_core_tvalid), .s_core_tready(s_core_tready),
        .m_rsp_tdata(m_rsp_tdata), .m_rsp_tdest(m_rsp_tdest), .m_rsp_tvalid(m_rsp_tvalid),
        .m_rsp_tready(m_rsp_tready), .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_s_req_tready"},  32'(s_req_tready), 32'd0);
        chk({tag, "_m_core_tvalid"}, 32'(m_core_tvalid), 32'd0);
        chk({tag, "_m_core_tdata"},  m_core_tdata, 32'd0);
        chk({tag, "_s_core_tready"}, 32'(s_core_tready), 32'd0);
        chk({tag, "_m_rsp_tvalid"},  32'(m_rsp_tvalid), 32'd0);
        chk({tag, "_m_rsp_tdest"},   32'(m_rsp_tdest), 32'd0);
        chk({tag, "_outstanding"},   32'(outstanding), 32'd0);
        chk({tag, "_err_orphan"},    32'(err_orphan), 32'd0);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((sb_q.size() > 0 || exp_grant_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(sb_q.size() + exp_grant_q.size()), 32'd0);
    endtask

    // Stub for requesters and core: observe handshakes mid-cycle, update after the edge.
    initial begin
        int          g;
        logic [31:0] d;
        rsp_t        e;
        s_req_tvalid  = '0;
        s_req_tdata   = '0;
        s_core_tvalid = 1'b0;
        s_core_tdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_core_tvalid && m_core_tready) begin
                if (exp_grant_q.size() == 0) chk("unexpected_beat", 32'(exp_grant_q.size()), 32'd1);
                else begin
                    g = exp_grant_q.pop_front();
                    d = req_q[g].pop_front();
                    chk("grant_onehot", 32'(s_req_tready), 32'(1 << g));
                    chk("core_tdata", m_core_tdata, d);
                    sb_q.push_back(rsp_t'{dest: IW'(g), data: d + K});
                    core_q.push_back(d + K);
                    hs_cyc_q.push_back(cyc);
                end
            end
            if (m_rsp_tvalid && m_rsp_tready) begin
                if (sb_q.size() == 0) chk("unexpected_rsp", 32'(sb_q.size()), 32'd1);
                else begin
                    e = sb_q.pop_front();
                    chk("rsp_tdata", m_rsp_tdata, e.data);
                    chk("rsp_tdest", 32'(m_rsp_tdest), 32'(e.dest));
                end
                if (core_q.size() > 0) void'(core_q.pop_front());
                if (!core_en) rel_done++;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                s_req_tvalid[i]        = (req_q[i].size() > 0);
                s_req_tdata[i*DW +: DW] = (req_q[i].size() > 0) ? req_q[i][0] : 32'd0;
            end
            s_core_tvalid = orphan_drv || (core_q.size() > 0 && (core_en || rel_done < rel_req));
            s_core_tdata  = orphan_drv ? 32'hDEAD0000 : ((core_q.size() > 0) ? core_q[0] : 32'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        m_core_tready = 1'b1;
        m_rsp_tready  = 1'b1;
        tick();
        tick();
        rst_checks("reset");

        // Contention: all four valid from the first cycle after release.
        for (int i = 0; i < NR; i++) begin
            req_q[i].push_back(32'hC0DE0000 + 32'(i));
            exp_grant_q.push_back(i);
        end
        tick();
        rst = 1'b0;
        wait_drain("contention_drain", 40);
        chk("contention_beats", 32'(hs_cyc_q.size()), 32'd4);
        if (hs_cyc_q.size() == 4)
            for (int i = 1; i < 4; i++)
                chk("contention_gap", 32'(hs_cyc_q[i] - hs_cyc_q[i-1]), 32'd2);
        hs_cyc_q.delete();

        // Single requester: latency and outstanding 0->1->0.
        req_q[2].push_back(32'h12345678);
        exp_grant_q.push_back(2);
        tick();
        chk("single_pre_valid", 32'(m_core_tvalid), 32'd0);
        tick();
        chk("single_core_valid", 32'(m_core_tvalid), 32'd1);
        chk("single_out0", 32'(outstanding), 32'd0);
        tick();
        chk("single_out1", 32'(outstanding), 32'd1);
        chk("single_rsp_data", m_rsp_tdata, 32'hBE024579);
        chk("single_rsp_dest", 32'(m_rsp_tdest), 32'd2);
        tick();
        chk("single_out_back0", 32'(outstanding), 32'd0);
        wait_drain("single_drain", 20);

        // Core backpressure during a grant on requester 1.
        m_core_tready = 1'b0;
        req_q[1].push_back(32'hB0B00001);
        exp_grant_q.push_back(1);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(m_core_tvalid), 32'd1);
            chk("bp_data", m_core_tdata, 32'hB0B00001);
            chk("bp_no_ready", 32'(s_req_tready), 32'd0);
            if (k == 0) begin
                req_q[2].push_back(32'hB0B00002);
                req_q[0].push_back(32'hB0B00000);
                exp_grant_q.push_back(2);
                exp_grant_q.push_back(0);
            end
            tick();
        end
        m_core_tready = 1'b1;
        wait_drain("bp_drain", 40);

        // Full: results withheld, nine beats offered.
        core_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            req_q[3].push_back(32'hF0000000 + 32'(i));
            exp_grant_q.push_back(3);
        end
        for (int i = 0; i < 30; i++) tick();
        chk("full_out8", 32'(outstanding), 32'd8);
        chk("full_blocked", 32'(m_core_tvalid), 32'd0);
        chk("full_ninth_held", 32'(exp_grant_q.size()), 32'd1);
        tick();
        chk("full_still_blocked", 32'(m_core_tvalid), 32'd0);
        rel_req++;
        tick();
        chk("full_rsp_valid", 32'(m_rsp_tvalid), 32'd1);
        chk("full_pop_cycle_blocked", 32'(m_core_tvalid), 32'd0);
        chk("full_pop_cycle_out", 32'(outstanding), 32'd8);
        tick();
        chk("full_after_pop_out", 32'(outstanding), 32'd7);
        chk("full_after_pop_idle", 32'(m_core_tvalid), 32'd0);
        tick();
        chk("full_ninth_grant", 32'(m_core_tvalid), 32'd1);
        chk("full_ninth_data", m_core_tdata, 32'hF0000008);
        core_en = 1'b1;
        wait_drain("full_drain", 60);

        // Orphan: core result with nothing pending.
        orphan_drv = 1'b1;
        tick();
        chk("orphan_core_ready", 32'(s_core_tready), 32'd0);
        chk("orphan_rsp_valid", 32'(m_rsp_tvalid), 32'd0);
        chk("orphan_not_yet", 32'(err_orphan), 32'd0);
        tick();
        chk("orphan_set", 32'(err_orphan), 32'd1);
        orphan_drv = 1'b0;
        tick();
        tick();
        chk("orphan_sticky", 32'(err_orphan), 32'd1);

        // Mid-operation reset: three in flight and a held grant.
        core_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_q[0].push_back(32'h5EED0000 + 32'(i));
            exp_grant_q.push_back(0);
        end
        begin
            int n = 0;
            while (exp_grant_q.size() > 0 && n < 30) begin
                tick();
                n++;
            end
        end
        chk("mid_issued", 32'(exp_grant_q.size()), 32'd0);
        tick();
        m_core_tready = 1'b0;
        req_q[2].push_back(32'h5EED0002);
        exp_grant_q.push_back(2);
        tick();
        tick();
        tick();
        chk("mid_grant_held", 32'(m_core_tvalid), 32'd1);
        chk("mid_out3", 32'(outstanding), 32'd3);
        rst = 1'b1;
        #1;
        rst_checks("midrst");
        exp_grant_q.delete();
        sb_q.delete();
        req_q[2].delete();
        core_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_orphan", 32'(err_orphan), 32'd1);
        chk("post_rst_out", 32'(outstanding), 32'd0);
        chk("post_rst_idle", 32'(m_core_tvalid), 32'd0);
        core_q.delete();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
